fpu_buffer_fill_ctrl: RTL and testbench
=======================================

FPU_BUFFER_FILL_CTRL -- requirements
Module: fpu_buffer_fill_ctrl

Interface
REQ-001 SHALL have parameter BUFFER_DEPTH, default 512, bytes per read-bank column.
REQ-002 SHALL have parameter COL_WIDTH, default 10, read-bank columns per buffer.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 4, maximum in-flight memory reads (power of two).
REQ-004 SHALL use BA=$clog2(BUFFER_DEPTH) and CA=$clog2(COL_WIDTH) as derived widths.
REQ-005 SHALL have ports: clk in 1, rising-edge clock; rst_n in 1, reset, asynchronous, active-low.
REQ-006 SHALL have ports: start in 1, fill request pulse; base_addr in 32, byte address of column 0; stride in 32, byte distance between columns; fill_rows in BA+1, bytes per column (bits [2:0] ignored).
REQ-007 SHALL have ports: mem_req_valid out 1; mem_req_ready in 1; mem_req_addr out 32, 8-byte-aligned read address.
REQ-008 SHALL have ports: mem_rsp_valid in 1, in-order read data strobe; mem_rsp_data in 64.
REQ-009 SHALL have ports: wr_en_rd_buffer out 1; rd_buffer_sel out 1, buffer being filled; request_write_address out BA+CA, {column, byte offset}; request_data_in out 64.
REQ-010 SHALL have ports: buf_release in 1, consumer frees oldest full buffer; full_count out 2; busy out 1; fill_done out 1, one-cycle pulse.

Function
REQ-011 SHALL implement states IDLE, REQ, DRAIN; busy=1 in REQ and DRAIN.
REQ-012 IDLE->REQ on start when full_count<2 and fill_rows[BA:3]!=0; start otherwise ignored; start while busy ignored.
REQ-013 At IDLE->REQ SHALL latch base_addr, stride, beats_per_col=fill_rows[BA:3]; clear issue and write counters (col, row).
REQ-014 In REQ SHALL assert mem_req_valid while outstanding<MAX_OUTSTANDING; mem_req_addr=base+col*stride+row*8, col-major order (row inner, col outer).
REQ-015 mem_req_valid and mem_req_addr SHALL hold stable until mem_req_ready; a beat is issued on valid&&ready.
REQ-016 REQ->DRAIN when the COL_WIDTH*beats_per_col-th request issues.
REQ-017 Each mem_rsp_valid with outstanding>0 SHALL, same cycle, assert wr_en_rd_buffer with request_data_in=mem_rsp_data and request_write_address={wcol[CA-1:0], wrow*8 [BA-1:0]}, then advance write counter.
REQ-018 mem_rsp_valid with outstanding==0 SHALL be dropped (no write).
REQ-019 outstanding SHALL +1 on issue, -1 on accepted response, unchanged on both same cycle; never exceeds MAX_OUTSTANDING.
REQ-020 DRAIN->IDLE on the final response write; next cycle fill_done=1, rd_buffer_sel toggles, full_count+1.
REQ-021 full_count SHALL -1 on buf_release when >0; release with full_count==0 ignored; simultaneous fill completion and release leaves it unchanged.
REQ-022 Row/column counters SHALL wrap row to 0 and increment col at row==beats_per_col-1.

Reset
REQ-023 On rst_n low: state IDLE, all counters 0, outstanding 0, rd_buffer_sel 0, full_count 0, all valid/enable/pulse outputs 0, address/data outputs 0.
REQ-024 Reset mid-fill SHALL abandon the fill; responses arriving afterward are dropped per REQ-018.

Configuration
REQ-025 With FPU_FILL_PERF_EN defined SHALL add output perf_stall 32, counting cycles with mem_req_valid&&!mem_req_ready, saturating at all-ones, cleared by reset only.
REQ-026 Without FPU_FILL_PERF_EN the port and counter SHALL not exist; all other behaviour identical.

Verification
REQ-027 Defaults, base=0x1000, stride=0x200, fill_rows=16, ready=1, 1-cycle response -> 20 requests 0x1000,0x1008,0x1200...0x2208; writes to addresses {0,0},{0,8}...{9,8}; fill_done once; rd_buffer_sel 0->1; full_count 1.
REQ-028 mem_req_ready low 5 cycles on beat 3 -> mem_req_addr held constant; with FPU_FILL_PERF_EN, perf_stall=5.
REQ-029 Responses withheld -> exactly 4 requests issued, valid low until first response, then issue resumes.
REQ-030 Two fills with no release -> full_count 2; third start ignored (busy stays 0); buf_release -> full_count 1, start accepted.
REQ-031 rst_n low mid-REQ with 3 outstanding, then 3 late responses -> no wr_en_rd_buffer, all outputs at reset values.
REQ-032 fill_rows=5 -> start ignored; fill_rows=8 -> 10 beats, one per column.

Source files
------------

// File: rtl/fpu_buffer_fill_ctrl.sv
// Fills one of two read banks with column-major memory reads; states IDLE (wait start) | REQ (issuing) | DRAIN (await last data).
// Defining FPU_FILL_PERF_EN adds the perf_stall request-backpressure counter output.
module fpu_buffer_fill_ctrl #(
  parameter int BUFFER_DEPTH    = 512,
  parameter int COL_WIDTH       = 10,
  parameter int MAX_OUTSTANDING = 4,
  localparam int BA = $clog2(BUFFER_DEPTH),
  localparam int CA = $clog2(COL_WIDTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [31:0]    base_addr,
  input  logic [31:0]    stride,
  input  logic [BA:0]    fill_rows,
  output logic           mem_req_valid,
  input  logic           mem_req_ready,
  output logic [31:0]    mem_req_addr,
  input  logic           mem_rsp_valid,
  input  logic [63:0]    mem_rsp_data,
  output logic           wr_en_rd_buffer,
  output logic           rd_buffer_sel,
  output logic [BA+CA-1:0] request_write_address,
  output logic [63:0]    request_data_in,
  input  logic           buf_release,
  output logic [1:0]     full_count,
  output logic           busy,
  output logic           fill_done
`ifdef FPU_FILL_PERF_EN
  , output logic [31:0]  perf_stall
`endif
);

  localparam int RW = BA - 2;
  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN} state_e;

  state_e        state_q;
  logic [31:0]   col_base_q, stride_q;
  logic [RW-1:0] beats_q, irow_q, wrow_q;
  logic [CA-1:0] icol_q, wcol_q;
  logic [OW-1:0] outst_q;
  logic          sel_q, done_q;
  logic [1:0]    full_q;

  logic issue, irow_last, icol_last, wrow_last, wcol_last, fill_fin, accept, release_ok;
  logic unused_rows;

  assign unused_rows = ^fill_rows[2:0];

  assign mem_req_valid = (state_q == S_REQ) && (outst_q < OW'(MAX_OUTSTANDING));
  assign mem_req_addr  = col_base_q + {{(29-RW){1'b0}}, irow_q, 3'b000};
  assign issue         = mem_req_valid && mem_req_ready;

  // Responses are only meaningful while reads are in flight; strays leave the bank untouched.
  assign wr_en_rd_buffer       = mem_rsp_valid && (outst_q != '0);
  assign request_data_in       = wr_en_rd_buffer ? mem_rsp_data : '0;
  assign request_write_address = wr_en_rd_buffer ? {wcol_q, wrow_q[BA-4:0], 3'b000} : '0;

  assign irow_last  = (irow_q == beats_q - RW'(1));
  assign icol_last  = (icol_q == CA'(COL_WIDTH - 1));
  assign wrow_last  = (wrow_q == beats_q - RW'(1));
  assign wcol_last  = (wcol_q == CA'(COL_WIDTH - 1));
  assign fill_fin   = (state_q == S_DRAIN) && wr_en_rd_buffer && wrow_last && wcol_last;
  assign accept     = (state_q == S_IDLE) && start && (full_q < 2'd2) && (fill_rows[BA:3] != '0);
  assign release_ok = buf_release && (full_q != 2'd0);

  assign busy          = (state_q != S_IDLE);
  assign rd_buffer_sel = sel_q;
  assign full_count    = full_q;
  assign fill_done     = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      col_base_q <= '0;
      stride_q   <= '0;
      beats_q    <= '0;
      irow_q     <= '0;
      icol_q     <= '0;
      wrow_q     <= '0;
      wcol_q     <= '0;
      outst_q    <= '0;
      sel_q      <= 1'b0;
      done_q     <= 1'b0;
      full_q     <= 2'd0;
    end else begin
      done_q <= 1'b0;
      if (issue) begin
        if (irow_last) begin
          irow_q     <= '0;
          icol_q     <= icol_q + CA'(1);
          col_base_q <= col_base_q + stride_q;
        end else begin
          irow_q <= irow_q + RW'(1);
        end
      end
      if (wr_en_rd_buffer) begin
        if (wrow_last) begin
          wrow_q <= '0;
          wcol_q <= wcol_q + CA'(1);
        end else begin
          wrow_q <= wrow_q + RW'(1);
        end
      end
      if (issue && !wr_en_rd_buffer)      outst_q <= outst_q + OW'(1);
      else if (!issue && wr_en_rd_buffer) outst_q <= outst_q - OW'(1);
      if (fill_fin && !release_ok)      full_q <= full_q + 2'd1;
      else if (!fill_fin && release_ok) full_q <= full_q - 2'd1;
      case (state_q)
        S_IDLE: if (accept) begin
          state_q    <= S_REQ;
          col_base_q <= base_addr;
          stride_q   <= stride;
          beats_q    <= fill_rows[BA:3];
          irow_q     <= '0;
          icol_q     <= '0;
          wrow_q     <= '0;
          wcol_q     <= '0;
        end
        S_REQ:   if (issue && irow_last && icol_last) state_q <= S_DRAIN;
        S_DRAIN: if (fill_fin) begin
          state_q <= S_IDLE;
          done_q  <= 1'b1;
          sel_q   <= ~sel_q;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef FPU_FILL_PERF_EN
  logic [31:0] stall_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else if (mem_req_valid && !mem_req_ready && (stall_q != '1)) stall_q <= stall_q + 32'd1;
  end
  assign perf_stall = stall_q;
`endif

endmodule

// File: tb/tb_fpu_buffer_fill_ctrl.sv
// Directed bench for fpu_buffer_fill_ctrl: table of fill configurations plus handwritten stall/withhold/full/reset sequences.
module tb_fpu_buffer_fill_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [31:0] base_addr = '0, stride = '0;
  logic [9:0]  fill_rows = '0;
  logic        mem_req_valid, mem_req_ready = 1'b1;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [63:0] mem_rsp_data = '0;
  logic        wr_en_rd_buffer, rd_buffer_sel;
  logic [12:0] request_write_address;
  logic [63:0] request_data_in;
  logic        buf_release = 1'b0;
  logic [1:0]  full_count;
  logic        busy, fill_done;
`ifdef FPU_FILL_PERF_EN
  logic [31:0] perf_stall;
`endif

  fpu_buffer_fill_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .stride(stride),
    .fill_rows(fill_rows), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .wr_en_rd_buffer(wr_en_rd_buffer), .rd_buffer_sel(rd_buffer_sel),
    .request_write_address(request_write_address), .request_data_in(request_data_in),
    .buf_release(buf_release), .full_count(full_count), .busy(busy), .fill_done(fill_done)
`ifdef FPU_FILL_PERF_EN
    , .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  // Memory model: one-cycle in-order responses, data = {~addr, addr}; hold_rsp withholds them.
  logic [31:0] req_log[$];
  logic [63:0] rsp_q[$];
  logic [12:0] wa_log[$];
  logic [63:0] wd_log[$];
  int          done_cnt = 0;
  bit          hold_rsp = 1'b0;

  always @(negedge clk) begin
    if (rsp_q.size() > 0 && !hold_rsp) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = rsp_q.pop_front();
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
    end
    if (rst_n && mem_req_valid && mem_req_ready) begin
      req_log.push_back(mem_req_addr);
      rsp_q.push_back({~mem_req_addr, mem_req_addr});
    end
    #2;
    if (wr_en_rd_buffer) begin
      wa_log.push_back(request_write_address);
      wd_log.push_back(request_data_in);
    end
    if (fill_done) done_cnt++;
  end

  int total = 0, bad = 0;
  logic [31:0] cur_base, cur_stride;
  int cur_beats, rq0, wr0, dn0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_req(input int n);
    return cur_base + 32'(n / cur_beats) * cur_stride + 32'((n % cur_beats) * 8);
  endfunction

  function automatic logic [12:0] exp_wa(input int n);
    return 13'(((n / cur_beats) << 9) | ((n % cur_beats) << 3));
  endfunction

  task automatic launch(input logic [31:0] b, input logic [31:0] s, input logic [9:0] r);
    @(posedge clk); #1;
    cur_base = b; cur_stride = s; cur_beats = int'(r[9:3]);
    rq0 = req_log.size(); wr0 = wa_log.size(); dn0 = done_cnt;
    base_addr = b; stride = s; fill_rows = r; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit && done_cnt == dn0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    #3;
    chk("done_once", 64'(done_cnt - dn0), 64'd1);
    chk("idle_after_done", 64'(busy), 64'd0);
  endtask

  task automatic verify(input int n);
    chk("req_count", 64'(req_log.size() - rq0), 64'(n));
    chk("wr_count", 64'(wa_log.size() - wr0), 64'(n));
    for (int i = 0; i < n && rq0 + i < req_log.size(); i++)
      chk("req_addr", 64'(req_log[rq0+i]), 64'(exp_req(i)));
    for (int i = 0; i < n && wr0 + i < wa_log.size(); i++) begin
      chk("wr_addr", 64'(wa_log[wr0+i]), 64'(exp_wa(i)));
      chk("wr_data", wd_log[wr0+i], {~exp_req(i), exp_req(i)});
    end
  endtask

  task automatic pulse_release;
    @(posedge clk); #1; buf_release = 1'b1;
    @(posedge clk); #1; buf_release = 1'b0;
  endtask

  task automatic apply_reset;
    @(posedge clk); #1; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
  endtask

  task automatic chk_idle(input string p);
    chk({p, "_req_valid"}, 64'(mem_req_valid), 64'd0);
    chk({p, "_req_addr"}, 64'(mem_req_addr), 64'd0);
    chk({p, "_wr_en"}, 64'(wr_en_rd_buffer), 64'd0);
    chk({p, "_wr_addr"}, 64'(request_write_address), 64'd0);
    chk({p, "_wr_data"}, request_data_in, 64'd0);
    chk({p, "_sel"}, 64'(rd_buffer_sel), 64'd0);
    chk({p, "_full"}, 64'(full_count), 64'd0);
    chk({p, "_busy"}, 64'(busy), 64'd0);
    chk({p, "_done"}, 64'(fill_done), 64'd0);
  endtask

  typedef struct {
    logic [31:0] base;
    logic [31:0] strd;
    logic [9:0]  rows;
    bit          acc;
    int          nreq;
    bit          sel;
  } vec_t;

  initial begin
    vec_t vt[6];
    vt[0] = '{32'h0000_1000, 32'h200,  10'd16,  1'b1, 20, 1'b1};
    vt[1] = '{32'h0000_4000, 32'h40,   10'd8,   1'b1, 10, 1'b0};
    vt[2] = '{32'h0000_5000, 32'h100,  10'd5,   1'b0, 0,  1'b0};
    vt[3] = '{32'h0000_5000, 32'h100,  10'd0,   1'b0, 0,  1'b0};
    vt[4] = '{32'h8000_0000, 32'h1000, 10'h01F, 1'b1, 30, 1'b1};
    vt[5] = '{32'hFFFF_FF00, 32'h80,   10'd64,  1'b1, 80, 1'b0};

    @(negedge clk); #2;
    chk_idle("reset");
    @(posedge clk); #1; rst_n = 1'b1;

    for (int k = 0; k < 6; k++) begin
      launch(vt[k].base, vt[k].strd, vt[k].rows);
      chk("accept_busy", 64'(busy), 64'(vt[k].acc));
      if (vt[k].acc) begin
        wait_done(400);
        verify(vt[k].nreq);
        chk("full_after_fill", 64'(full_count), 64'd1);
        pulse_release;
        chk("full_after_rel", 64'(full_count), 64'd0);
      end else begin
        repeat (4) @(negedge clk);
        #2;
        chk("rej_busy", 64'(busy), 64'd0);
        verify(0);
      end
      chk("sel", 64'(rd_buffer_sel), 64'(vt[k].sel));
    end

    // Backpressure on the fourth beat: request must hold still for five cycles.
    apply_reset;
    launch(32'h1000, 32'h200, 10'd16);
    for (int i = 0; i < 50 && req_log.size() - rq0 < 3; i++) begin @(posedge clk); #1; end
    mem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #2;
      chk("stall_valid", 64'(mem_req_valid), 64'd1);
      chk("stall_addr", 64'(mem_req_addr), 64'h1208);
    end
    @(posedge clk); #1; mem_req_ready = 1'b1;
    wait_done(400);
    verify(20);
`ifdef FPU_FILL_PERF_EN
    chk("perf_stall", 64'(perf_stall), 64'd5);
`endif
    pulse_release;

    // Withheld responses cap the in-flight window.
    hold_rsp = 1'b1;
    launch(32'h1000, 32'h200, 10'd16);
    repeat (10) @(negedge clk);
    #2;
    chk("held_reqs", 64'(req_log.size() - rq0), 64'd4);
    chk("held_valid", 64'(mem_req_valid), 64'd0);
    hold_rsp = 1'b0;
    wait_done(400);
    verify(20);
    pulse_release;

    // Two full buffers block a third fill until one is released.
    apply_reset;
    pulse_release;
    chk("rel_empty", 64'(full_count), 64'd0);
    launch(32'h2000, 32'h100, 10'd8); wait_done(200); verify(10);
    launch(32'h3000, 32'h100, 10'd8); wait_done(200); verify(10);
    chk("full_two", 64'(full_count), 64'd2);
    launch(32'h4000, 32'h100, 10'd8);
    chk("full_rej_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    #2;
    chk("full_rej_reqs", 64'(req_log.size() - rq0), 64'd0);
    pulse_release;
    chk("full_rel", 64'(full_count), 64'd1);
    launch(32'h4000, 32'h100, 10'd8);
    chk("full_acc_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 200 && wa_log.size() - wr0 < 9; i++) begin @(negedge clk); #2; end
    @(posedge clk); #1; buf_release = 1'b1;
    @(posedge clk); #1; buf_release = 1'b0;
    wait_done(50);
    verify(10);
    chk("full_simul", 64'(full_count), 64'd1);
    chk("sel_three", 64'(rd_buffer_sel), 64'd1);

    // Reset with three reads in flight; late responses must not write.
    apply_reset;
    hold_rsp = 1'b1;
    launch(32'h1000, 32'h200, 10'd16);
    for (int i = 0; i < 50 && req_log.size() - rq0 < 3; i++) begin @(posedge clk); #1; end
    mem_req_ready = 1'b0;
    #2; rst_n = 1'b0;
    @(negedge clk); #2;
    chk_idle("in_reset");
    @(posedge clk); #1;
    rst_n = 1'b1; mem_req_ready = 1'b1; hold_rsp = 1'b0;
    wr0 = wa_log.size();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #2;
      chk("late_wr_en", 64'(wr_en_rd_buffer), 64'd0);
    end
    chk("late_writes", 64'(wa_log.size() - wr0), 64'd0);
    chk("late_rsp_drained", 64'(rsp_q.size()), 64'd0);
    chk_idle("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
